// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/execute/writeback sequencer for the single-issue NPC core.
// Owns pc, the latched instruction, halt/error status and the cycle/retire counters.
module core_ctrl_fsm #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    output logic [31:0]      ifu_req_addr,
    input  logic             ifu_resp_valid,
    input  logic [31:0]      ifu_resp_inst,
    output logic [31:0]      inst_q,
    output logic [31:0]      pc,
    input  logic             is_ebreak,
    input  logic             inst_not_ipl,
    input  logic [31:0]      a0_value,
    output logic             rf_we,
    output logic             halted,
    output logic [31:0]      halt_ret,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int TMO_W = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        inst_lat_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               req_q;
    logic               rf_we_q;
    logic               halted_q;
    logic [31:0]        halt_ret_q;
    logic               err_q;
    logic [1:0]         err_code_q;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            inst_lat_q <= 32'd0;
            tmo_q      <= '0;
            req_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
            halt_ret_q <= 32'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            // HALT and ERR freeze everything, including the cycle counter.
            if (state_q != S_HALT && state_q != S_ERR) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end

            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    tmo_q   <= '0;
                end
                S_FETCH: begin
                    // A response on the last allowed cycle still beats the timeout.
                    if (ifu_resp_valid) begin
                        inst_lat_q <= ifu_resp_inst;
                        tmo_q      <= '0;
                        req_q      <= 1'b0;
                        state_q    <= S_EXEC;
                    end else if (tmo_q == TMO_LAST) begin
                        req_q      <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'd2;
                        state_q    <= S_ERR;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_EXEC: begin
                    if (is_ebreak) begin
                        halted_q   <= 1'b1;
                        halt_ret_q <= a0_value;
                        instret_q  <= instret_q + CNT_W'(1);
                        state_q    <= S_HALT;
                    end else if (inst_not_ipl) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'd1;
                        state_q    <= S_ERR;
                    end else begin
                        rf_we_q <= 1'b1;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    rf_we_q   <= 1'b0;
                    pc_q      <= pc_q + 32'd4;
                    instret_q <= instret_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    state_q   <= S_FETCH;
                end
                S_HALT, S_ERR: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign ifu_req_valid = req_q;
    assign ifu_req_addr  = pc_q;
    assign pc            = pc_q;
    assign inst_q        = inst_lat_q;
    assign rf_we         = rf_we_q;
    assign halted        = halted_q;
    assign halt_ret      = halt_ret_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: directed scenarios with literal expectations, then
// randomized fetch latencies, instruction mixes and resets against a phase-level model.
module tb_core_ctrl_fsm;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI5  = 32'h0050_0093;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_inst;
    logic [31:0] inst_q;
    logic [31:0] pc;
    logic        is_ebreak;
    logic        inst_not_ipl;
    logic [31:0] a0_value;
    logic        rf_we;
    logic        halted;
    logic [31:0] halt_ret;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_ctrl_fsm #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
        .inst_q(inst_q), .pc(pc),
        .is_ebreak(is_ebreak), .inst_not_ipl(inst_not_ipl), .a0_value(a0_value),
        .rf_we(rf_we), .halted(halted), .halt_ret(halt_ret),
        .err(err), .err_code(err_code),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // Model phases: where the instruction currently is in its life.
    localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_WB = 3, P_HALT = 4, P_ERR = 5;
    int          m_phase;
    int          m_wait_cycles;
    logic [31:0] m_pc, m_inst, m_ret, m_cyc, m_retired;
    logic        m_halted, m_err;
    logic [1:0]  m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (rst) begin
            m_phase = P_BOOT; m_pc = RST_PC; m_inst = 0; m_wait_cycles = 0;
            m_halted = 0; m_ret = 0; m_err = 0; m_code = 0; m_cyc = 0; m_retired = 0;
        end else begin
            if (!(m_halted || m_err)) m_cyc = m_cyc + 1;
            case (m_phase)
                P_BOOT: begin m_phase = P_FETCH; m_wait_cycles = 0; end
                P_FETCH: begin
                    m_wait_cycles++;
                    if (ifu_resp_valid) begin
                        m_inst = ifu_resp_inst; m_phase = P_EXEC;
                    end else if (m_wait_cycles >= TMO) begin
                        m_phase = P_ERR; m_err = 1; m_code = 2;
                    end
                end
                P_EXEC: begin
                    if (is_ebreak) begin
                        m_phase = P_HALT; m_halted = 1; m_ret = a0_value; m_retired = m_retired + 1;
                    end else if (inst_not_ipl) begin
                        m_phase = P_ERR; m_err = 1; m_code = 1;
                    end else begin
                        m_phase = P_WB;
                    end
                end
                P_WB: begin
                    m_pc = m_pc + 4; m_retired = m_retired + 1;
                    m_phase = P_FETCH; m_wait_cycles = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("req_valid", 32'(ifu_req_valid), 32'(m_phase == P_FETCH));
        chk("req_addr",  ifu_req_addr, m_pc);
        chk("pc",        pc, m_pc);
        chk("inst_q",    inst_q, m_inst);
        chk("rf_we",     32'(rf_we), 32'(m_phase == P_WB));
        chk("halted",    32'(halted), 32'(m_halted));
        chk("halt_ret",  halt_ret, m_ret);
        chk("err",       32'(err), 32'(m_err));
        chk("err_code",  32'(err_code), 32'(m_code));
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret",   instret_cnt, m_retired);
        chk("halt_err_excl", 32'(halted & err), 32'd0);
    endtask

    // Stand-in decoder: OP-IMM and ebreak are the only implemented encodings.
    task automatic decode();
        is_ebreak    = (inst_q == EBREAK);
        inst_not_ipl = (inst_q != EBREAK) && (inst_q[6:0] != 7'h13);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        decode();
    endtask

    function automatic logic [31:0] gen_inst();
        int sel = $urandom_range(0, 24);
        logic [31:0] r = $urandom;
        if (sel == 0) return EBREAK;
        if (sel == 1) return {r[31:7], 7'h33};
        return {r[31:7], 7'h13};
    endfunction

    int fetch_wait;
    int idle;

    initial begin
        rst = 1; ifu_resp_valid = 0; ifu_resp_inst = 0; a0_value = 0;
        is_ebreak = 0; inst_not_ipl = 0;

        // T1: reset held three cycles, BOOT then FETCH
        repeat (3) tick();
        chk("t1_pc", pc, 32'h8000_0000);
        chk("t1_req_boot", 32'(ifu_req_valid), 32'd0);
        chk("t1_cyc", cycle_cnt, 32'd0);
        rst = 0;
        tick();
        chk("t1_req_fetch", 32'(ifu_req_valid), 32'd1);

        // T2: addi with zero-wait response
        ifu_resp_valid = 1; ifu_resp_inst = ADDI5;
        tick();
        ifu_resp_valid = 0;
        chk("t2_inst", inst_q, ADDI5);
        chk("t2_we_exec", 32'(rf_we), 32'd0);
        tick();
        chk("t2_we_wb", 32'(rf_we), 32'd1);
        tick();
        chk("t2_we_off", 32'(rf_we), 32'd0);
        chk("t2_pc", pc, 32'h8000_0004);
        chk("t2_instret", instret_cnt, 32'd1);

        // T3: ebreak with a0=0
        ifu_resp_valid = 1; ifu_resp_inst = EBREAK; a0_value = 0;
        tick();
        ifu_resp_valid = 0;
        tick();
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_ret", halt_ret, 32'd0);
        chk("t3_instret", instret_cnt, 32'd2);
        for (int i = 0; i < 4; i++) begin
            ifu_resp_valid = 1'($urandom_range(0, 1)); a0_value = $urandom;
            tick();
        end
        chk("t3_cyc_frozen", cycle_cnt, 32'd6);
        chk("t3_pc_frozen", pc, 32'h8000_0004);
        chk("t3_we", 32'(rf_we), 32'd0);

        // T6a: reset while halted
        ifu_resp_valid = 0; rst = 1;
        tick();
        rst = 0;
        chk("t6_halt_clr", 32'(halted), 32'd0);
        chk("t6_instret_clr", instret_cnt, 32'd0);
        chk("t6_pc", pc, RST_PC);

        // T4: unimplemented instruction
        tick();
        ifu_resp_valid = 1; ifu_resp_inst = 32'h0000_0033;
        tick();
        ifu_resp_valid = 0;
        tick();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_code", 32'(err_code), 32'd1);
        chk("t4_pc", pc, RST_PC);
        repeat (3) tick();
        chk("t4_we", 32'(rf_we), 32'd0);

        // T5: fetch timeout, then response on the last allowed cycle
        rst = 1; tick(); rst = 0; tick();
        repeat (TMO - 1) tick();
        chk("t5_no_err_yet", 32'(err), 32'd0);
        chk("t5_still_req", 32'(ifu_req_valid), 32'd1);
        tick();
        chk("t5_tmo_err", 32'(err), 32'd1);
        chk("t5_tmo_code", 32'(err_code), 32'd2);
        rst = 1; tick(); rst = 0; tick();
        repeat (TMO - 1) tick();
        ifu_resp_valid = 1; ifu_resp_inst = ADDI5;
        tick();
        ifu_resp_valid = 0;
        chk("t5_late_ok", 32'(err), 32'd0);
        chk("t5_late_inst", inst_q, ADDI5);
        tick();
        chk("t5_late_we", 32'(rf_we), 32'd1);

        // T6b: reset mid-FETCH
        tick();
        rst = 1; tick(); rst = 0;
        chk("t6_fetch_req", 32'(ifu_req_valid), 32'd0);
        chk("t6_fetch_instret", instret_cnt, 32'd0);

        // Randomized traffic
        fetch_wait = -1; idle = 0;
        for (int n = 0; n < 4000; n++) begin
            a0_value = $urandom;
            if (m_phase == P_HALT || m_phase == P_ERR) idle++;
            if (idle > 4) begin
                rst = 1; idle = 0;
            end else begin
                rst = ($urandom_range(0, 299) == 0);
            end
            if (rst) fetch_wait = -1;
            if (m_phase == P_FETCH && !rst) begin
                if (fetch_wait < 0)
                    fetch_wait = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
                if (fetch_wait == 0) begin
                    ifu_resp_valid = 1; ifu_resp_inst = gen_inst(); fetch_wait = -1;
                end else begin
                    ifu_resp_valid = 0; ifu_resp_inst = $urandom; fetch_wait--;
                end
            end else begin
                if (m_phase != P_FETCH) fetch_wait = -1;
                ifu_resp_valid = 1'($urandom_range(0, 1)); ifu_resp_inst = $urandom;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
